lifo_arbiter: RTL

Arbiter and sequencer that shares one `lifo` stack between several producer and several consumer hardware threads on a single clock. It sits in front of the stack's write/read port and owns all of its handshake signals. Requests are granted round-robin within each class (producers, consumers) and alternate between classes. Each completed operation is reported back to the requester.

---
 rtl/lifo_pkg.sv | 10 +
 rtl/lifo_arbiter_rr_pick.sv | 27 ++
 rtl/lifo_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared types for the lifo arbiter: FSM states, served-class tag and default word width.
package lifo_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

  typedef enum logic {WRITE_C, READ_C} class_t;

  localparam int DATA_W_DEF = 10;

endpackage

// File: rtl/lifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] win,
  output logic [N-1:0]  mask
);

  // Scanning from the far end lets the nearest requester after ptr overwrite the rest.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        win = IW'((int'(ptr) + i) % N);
      end
    end
    mask[win] = any;
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one lifo stack between N_PROD producers and N_CONS consumers with
// round-robin inside each class and class alternation when both contend.
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_PROD  = 2,
  parameter int N_CONS  = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_PROD-1:0]             p_req,
  input  logic [N_PROD-1:0][DATA_W-1:0] p_data,
  output logic [N_PROD-1:0]             p_gnt,
  input  logic [N_CONS-1:0]             c_req,
  output logic [N_CONS-1:0]             c_gnt,
  output logic [N_CONS-1:0]             c_err,
  output logic [DATA_W-1:0]             c_data,
  output logic                          lf_write,
  output logic                          lf_read,
  output logic [DATA_W-1:0]             lf_datain,
  input  logic                          lf_full,
  input  logic                          lf_empty,
  input  logic                          lf_val,
  input  logic [DATA_W-1:0]             lf_dataout,
  output logic                          busy,
  output state_t                        fsm_state
);

  localparam int PW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int CW = (N_CONS > 1) ? $clog2(N_CONS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: p_req/c_req are levels held by the requester; the arbiter answers
  // with exactly one single-cycle p_gnt, c_gnt or c_err pulse per served request.
  state_t            state;
  class_t            last_class;
  logic [PW-1:0]     p_ptr;
  logic [CW-1:0]     c_ptr;
  logic [PW-1:0]     p_win_q;
  logic [CW-1:0]     c_win_q;
  logic [N_CONS-1:0] c_mask_q;
  logic [TW-1:0]     cnt;

  logic              p_any;
  logic [PW-1:0]     p_win;
  logic [N_PROD-1:0] p_mask;
  logic              c_any;
  logic [CW-1:0]     c_win;
  logic [N_CONS-1:0] c_mask;

  rr_pick #(.N(N_PROD)) u_prod_pick (
    .req  (p_req & {N_PROD{~lf_full}}),
    .ptr  (p_ptr),
    .any  (p_any),
    .win  (p_win),
    .mask (p_mask)
  );

  rr_pick #(.N(N_CONS)) u_cons_pick (
    .req  (c_req & {N_CONS{~lf_empty}}),
    .ptr  (c_ptr),
    .any  (c_any),
    .win  (c_win),
    .mask (c_mask)
  );

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_class <= READ_C;
      p_ptr      <= '0;
      c_ptr      <= '0;
      p_win_q    <= '0;
      c_win_q    <= '0;
      c_mask_q   <= '0;
      cnt        <= '0;
      lf_write   <= 1'b0;
      lf_read    <= 1'b0;
      lf_datain  <= '0;
      p_gnt      <= '0;
      c_gnt      <= '0;
      c_err      <= '0;
      c_data     <= '0;
    end else begin
      lf_write  <= 1'b0;
      lf_read   <= 1'b0;
      lf_datain <= '0;
      p_gnt     <= '0;
      c_gnt     <= '0;
      c_err     <= '0;
      case (state)
        IDLE: begin
          // A write wins unless a read is also eligible and the last service was a write.
          if (p_any && (!c_any || last_class == READ_C)) begin
            state     <= WRITE;
            lf_write  <= 1'b1;
            lf_datain <= p_data[p_win];
            p_gnt     <= p_mask;
            p_win_q   <= p_win;
          end else if (c_any) begin
            state    <= READ;
            lf_read  <= 1'b1;
            c_win_q  <= c_win;
            c_mask_q <= c_mask;
          end
        end
        WRITE: begin
          state      <= IDLE;
          last_class <= WRITE_C;
          p_ptr      <= (p_win_q == PW'(N_PROD - 1)) ? '0 : p_win_q + PW'(1);
        end
        READ: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (lf_val) begin
            c_data     <= lf_dataout;
            c_gnt      <= c_mask_q;
            state      <= IDLE;
            last_class <= READ_C;
            c_ptr      <= (c_win_q == CW'(N_CONS - 1)) ? '0 : c_win_q + CW'(1);
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            // Last waiting cycle: the error pulse lands TIMEOUT cycles after WAIT began.
            c_err      <= c_mask_q;
            state      <= IDLE;
            last_class <= READ_C;
            c_ptr      <= (c_win_q == CW'(N_CONS - 1)) ? '0 : c_win_q + CW'(1);
          end else if (cnt != TW'(TIMEOUT)) begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
